// File: rtl/simt_alu_pipe.sv
`timescale 1ns/1ps
// simt_alu_pipe: two-stage pipelined SIMT ALU between the operand collector
// and the CDB / SIMT stack / scoreboard. S1 holds the accepted instruction,
// S2 holds per-lane results and branch outcomes; all outputs come from S2.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on the same-side valid. The OC side uses
// Valid_OC_ALU / Ready_ALU_OC. The CDB side uses Valid_ALU_CDB / Ready_CDB_ALU,
// and the CDB payload is held stable while valid is high and ready is low.
// The SIMT and scoreboard outputs are one-cycle pulses with no backpressure.
module simt_alu_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_THREADS = 8,
    parameter int WARP_ID_W   = 3,
    parameter int SCB_ID_W    = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // operand collector side
    input  logic                              Valid_OC_ALU,
    output logic                              Ready_ALU_OC,
    input  logic [NUM_THREADS-1:0]            ActiveMask_OC_ALU,
    input  logic [WARP_ID_W-1:0]              WarpID_OC_ALU,
    input  logic [31:0]                       Instr_OC_ALU,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] Src1_Data_OC_ALU,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] Src2_Data_OC_ALU,
    input  logic [4:0]                        Dst_OC_ALU,
    input  logic [15:0]                       Imme_OC_ALU,
    input  logic                              Imme_Valid_OC_ALU,
    input  logic                              RegWrite_OC_ALU,
    input  logic [3:0]                        ALUop_OC_ALU,
    input  logic                              BEQ_OC_ALU,
    input  logic                              BLT_OC_ALU,
    input  logic [SCB_ID_W-1:0]               ScbID_OC_ALU,
    // CDB side
    output logic                              Valid_ALU_CDB,
    input  logic                              Ready_CDB_ALU,
    output logic [NUM_THREADS-1:0]            ActiveMask_ALU_CDB,
    output logic [31:0]                       Instr_ALU_CDB,
    output logic [WARP_ID_W-1:0]              WarpID_ALU_CDB,
    output logic                              RegWrite_ALU_CDB,
    output logic [4:0]                        Dst_ALU_CDB,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_ALU_CDB,
    // SIMT stack / PC side
    output logic                              Br_ALU_SIMT,
    output logic [NUM_THREADS-1:0]            BrOutcome_ALU_SIMT,
    output logic [WARP_ID_W-1:0]              WarpID_ALU_SIMT,
    output logic [31:0]                       TargetAddr_ALU_PC,
    // scoreboard side
    output logic                              Clear_Valid_ALU_Scb,
    output logic [WARP_ID_W-1:0]              Clear_WarpID_ALU_Scb,
    output logic [SCB_ID_W-1:0]               Clear_ScbID_ALU_Scb
);

    localparam int LANE_BITS = NUM_THREADS * DATA_WIDTH;
    localparam int SHAMT_W   = $clog2(DATA_WIDTH);
    localparam int HALF_W    = DATA_WIDTH / 2;

    // ---------------------------------------------------------------
    // Stage 1 registers
    // ---------------------------------------------------------------
    logic                   s1_valid;
    logic [NUM_THREADS-1:0] s1_mask;
    logic [WARP_ID_W-1:0]   s1_warp;
    logic [31:0]            s1_instr;
    logic [LANE_BITS-1:0]   s1_src1;
    logic [LANE_BITS-1:0]   s1_src2;
    logic [4:0]             s1_dst;
    logic [15:0]            s1_imme;
    logic                   s1_imme_valid;
    logic                   s1_regwrite;
    logic [3:0]             s1_aluop;
    logic                   s1_beq;
    logic                   s1_blt;
    logic [SCB_ID_W-1:0]    s1_scb;

    // ---------------------------------------------------------------
    // Stage 2 registers
    // ---------------------------------------------------------------
    logic                   s2_valid;
    logic                   s2_regwrite;
    logic                   s2_branch;
    logic [NUM_THREADS-1:0] s2_mask;
    logic [WARP_ID_W-1:0]   s2_warp;
    logic [31:0]            s2_instr;
    logic [4:0]             s2_dst;
    logic [LANE_BITS-1:0]   s2_data;
    logic [NUM_THREADS-1:0] s2_outcome;
    logic [15:0]            s2_target;
    logic [SCB_ID_W-1:0]    s2_scb;

    // ---------------------------------------------------------------
    // Flow control
    // ---------------------------------------------------------------
    logic s2_free;
    logic accept;
    logic s1_is_alu;
    logic s1_is_branch;
    logic s1_keep;
    logic cdb_valid;
    logic br_pulse;

    // S2 can take new contents unless it holds an ALU result the CDB refuses.
    // Branches in S2 always retire because SIMT and the scoreboard never stall.
    assign s2_free      = ~s2_valid | ~s2_regwrite | Ready_CDB_ALU;
    assign Ready_ALU_OC = ~s1_valid | s2_free;
    assign accept       = Valid_OC_ALU & Ready_ALU_OC;

    // Instructions that are neither ALU ops nor branches are dropped here:
    // they never make S2 valid, so they produce no output of any kind.
    assign s1_is_alu    = s1_regwrite;
    assign s1_is_branch = ~s1_regwrite & (s1_beq | s1_blt);
    assign s1_keep      = s1_valid & (s1_is_alu | s1_is_branch);

    assign cdb_valid = s2_valid & s2_regwrite;
    assign br_pulse  = s2_valid & s2_branch;

    // ---------------------------------------------------------------
    // Lane arithmetic helpers
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [SHAMT_W-1:0]    shamt;

    generate
        if (DATA_WIDTH > 16) begin : g_imm_sext
            assign imm_ext = {{(DATA_WIDTH-16){s1_imme[15]}}, s1_imme};
        end else begin : g_imm_trunc
            assign imm_ext = s1_imme[DATA_WIDTH-1:0];
        end
    endgenerate

    assign shamt = s1_imme[7 +: SHAMT_W];

    // One lane of the ALU. 'b' is the immediate-or-register operand,
    // 'b_reg' is always the register operand (sub ignores the immediate).
    function automatic logic [DATA_WIDTH-1:0] lane_result(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0] b_reg,
        input logic [SHAMT_W-1:0]    sh
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b_reg;
            4'd2: r = {{HALF_W{1'b0}}, a[HALF_W-1:0]} * {{HALF_W{1'b0}}, b[HALF_W-1:0]};
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = $signed(a) >>> sh;
            4'd7: r = a << sh;
            4'd8: r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Branch condition for one lane; BEQ wins when both flags are set.
    function automatic logic lane_taken(
        input logic                  beq,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic t;
        if (beq) t = (a == b);
        else     t = ($signed(a) < $signed(b));
        return t;
    endfunction

    logic [LANE_BITS-1:0]   lane_data;
    logic [NUM_THREADS-1:0] lane_outcome;

    // Per-lane results and branch outcomes from S1; inactive lanes give zero.
    always_comb begin
        lane_data    = '0;
        lane_outcome = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (s1_mask[i]) begin
                lane_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_result(
                    s1_aluop,
                    s1_src1[i*DATA_WIDTH +: DATA_WIDTH],
                    s1_imme_valid ? imm_ext : s1_src2[i*DATA_WIDTH +: DATA_WIDTH],
                    s1_src2[i*DATA_WIDTH +: DATA_WIDTH],
                    shamt);
                lane_outcome[i] = s1_is_branch & lane_taken(
                    s1_beq,
                    s1_src1[i*DATA_WIDTH +: DATA_WIDTH],
                    s1_src2[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1
    // ---------------------------------------------------------------
    // S1 occupancy: refills whenever it is ready, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (Ready_ALU_OC) begin
            s1_valid <= Valid_OC_ALU;
        end
    end

    // S1 payload: captured only on accept so it holds through a stall.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_mask       <= ActiveMask_OC_ALU;
            s1_warp       <= WarpID_OC_ALU;
            s1_instr      <= Instr_OC_ALU;
            s1_src1       <= Src1_Data_OC_ALU;
            s1_src2       <= Src2_Data_OC_ALU;
            s1_dst        <= Dst_OC_ALU;
            s1_imme       <= Imme_OC_ALU;
            s1_imme_valid <= Imme_Valid_OC_ALU;
            s1_regwrite   <= RegWrite_OC_ALU;
            s1_aluop      <= ALUop_OC_ALU;
            s1_beq        <= BEQ_OC_ALU;
            s1_blt        <= BLT_OC_ALU;
            s1_scb        <= ScbID_OC_ALU;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2
    // ---------------------------------------------------------------
    // S2 occupancy: takes S1 whenever S2 is free, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_keep;
        end
    end

    // S2 payload: loaded only when a kept instruction moves in.
    always_ff @(posedge clk) begin
        if (s2_free && s1_keep) begin
            s2_regwrite <= s1_is_alu;
            s2_branch   <= s1_is_branch;
            s2_mask     <= s1_mask;
            s2_warp     <= s1_warp;
            s2_instr    <= s1_instr;
            s2_dst      <= s1_dst;
            s2_data     <= lane_data;
            s2_outcome  <= lane_outcome;
            s2_target   <= s1_imme;
            s2_scb      <= s1_scb;
        end
    end

    // ---------------------------------------------------------------
    // Outputs: payloads read zero whenever their valid/pulse is low
    // ---------------------------------------------------------------
    assign Valid_ALU_CDB        = cdb_valid;
    assign ActiveMask_ALU_CDB   = cdb_valid ? s2_mask  : '0;
    assign Instr_ALU_CDB        = cdb_valid ? s2_instr : '0;
    assign WarpID_ALU_CDB       = cdb_valid ? s2_warp  : '0;
    assign RegWrite_ALU_CDB     = cdb_valid;
    assign Dst_ALU_CDB          = cdb_valid ? s2_dst   : '0;
    assign Dst_Data_ALU_CDB     = cdb_valid ? s2_data  : '0;

    assign Br_ALU_SIMT          = br_pulse;
    assign BrOutcome_ALU_SIMT   = br_pulse ? s2_outcome : '0;
    assign WarpID_ALU_SIMT      = br_pulse ? s2_warp    : '0;
    assign TargetAddr_ALU_PC    = br_pulse ? {16'b0, s2_target} : 32'b0;

    assign Clear_Valid_ALU_Scb  = br_pulse;
    assign Clear_WarpID_ALU_Scb = br_pulse ? s2_warp : '0;
    assign Clear_ScbID_ALU_Scb  = br_pulse ? s2_scb  : '0;

endmodule

// File: tb/tb_simt_alu_pipe.sv
`timescale 1ns/1ps
// Testbench for simt_alu_pipe: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a lane-level reference model.
module tb_simt_alu_pipe;

    localparam int DW    = 32;
    localparam int NT    = 8;
    localparam int WW    = 3;
    localparam int SW    = 2;
    localparam int CDB_W = NT*DW + NT + 32 + WW + 5;
    localparam int BR_W  = NT + WW + 32 + WW + SW;

    logic              clk;
    logic              rst_n;
    logic              Valid_OC_ALU;
    logic              Ready_ALU_OC;
    logic [NT-1:0]     ActiveMask_OC_ALU;
    logic [WW-1:0]     WarpID_OC_ALU;
    logic [31:0]       Instr_OC_ALU;
    logic [NT*DW-1:0]  Src1_Data_OC_ALU;
    logic [NT*DW-1:0]  Src2_Data_OC_ALU;
    logic [4:0]        Dst_OC_ALU;
    logic [15:0]       Imme_OC_ALU;
    logic              Imme_Valid_OC_ALU;
    logic              RegWrite_OC_ALU;
    logic [3:0]        ALUop_OC_ALU;
    logic              BEQ_OC_ALU;
    logic              BLT_OC_ALU;
    logic [SW-1:0]     ScbID_OC_ALU;
    logic              Valid_ALU_CDB;
    logic              Ready_CDB_ALU;
    logic [NT-1:0]     ActiveMask_ALU_CDB;
    logic [31:0]       Instr_ALU_CDB;
    logic [WW-1:0]     WarpID_ALU_CDB;
    logic              RegWrite_ALU_CDB;
    logic [4:0]        Dst_ALU_CDB;
    logic [NT*DW-1:0]  Dst_Data_ALU_CDB;
    logic              Br_ALU_SIMT;
    logic [NT-1:0]     BrOutcome_ALU_SIMT;
    logic [WW-1:0]     WarpID_ALU_SIMT;
    logic [31:0]       TargetAddr_ALU_PC;
    logic              Clear_Valid_ALU_Scb;
    logic [WW-1:0]     Clear_WarpID_ALU_Scb;
    logic [SW-1:0]     Clear_ScbID_ALU_Scb;

    simt_alu_pipe #(.DATA_WIDTH(DW), .NUM_THREADS(NT), .WARP_ID_W(WW), .SCB_ID_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Valid_OC_ALU(Valid_OC_ALU), .Ready_ALU_OC(Ready_ALU_OC),
        .ActiveMask_OC_ALU(ActiveMask_OC_ALU), .WarpID_OC_ALU(WarpID_OC_ALU),
        .Instr_OC_ALU(Instr_OC_ALU), .Src1_Data_OC_ALU(Src1_Data_OC_ALU),
        .Src2_Data_OC_ALU(Src2_Data_OC_ALU), .Dst_OC_ALU(Dst_OC_ALU),
        .Imme_OC_ALU(Imme_OC_ALU), .Imme_Valid_OC_ALU(Imme_Valid_OC_ALU),
        .RegWrite_OC_ALU(RegWrite_OC_ALU), .ALUop_OC_ALU(ALUop_OC_ALU),
        .BEQ_OC_ALU(BEQ_OC_ALU), .BLT_OC_ALU(BLT_OC_ALU), .ScbID_OC_ALU(ScbID_OC_ALU),
        .Valid_ALU_CDB(Valid_ALU_CDB), .Ready_CDB_ALU(Ready_CDB_ALU),
        .ActiveMask_ALU_CDB(ActiveMask_ALU_CDB), .Instr_ALU_CDB(Instr_ALU_CDB),
        .WarpID_ALU_CDB(WarpID_ALU_CDB), .RegWrite_ALU_CDB(RegWrite_ALU_CDB),
        .Dst_ALU_CDB(Dst_ALU_CDB), .Dst_Data_ALU_CDB(Dst_Data_ALU_CDB),
        .Br_ALU_SIMT(Br_ALU_SIMT), .BrOutcome_ALU_SIMT(BrOutcome_ALU_SIMT),
        .WarpID_ALU_SIMT(WarpID_ALU_SIMT), .TargetAddr_ALU_PC(TargetAddr_ALU_PC),
        .Clear_Valid_ALU_Scb(Clear_Valid_ALU_Scb), .Clear_WarpID_ALU_Scb(Clear_WarpID_ALU_Scb),
        .Clear_ScbID_ALU_Scb(Clear_ScbID_ALU_Scb)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog global time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [CDB_W-1:0] exp_cdb_q[$];
    logic [BR_W-1:0]  exp_br_q[$];

    task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // ---------------- CDB ready generation ----------------
    logic ready_manual;
    logic rand_en;
    logic rand_bit;
    assign Ready_CDB_ALU = rand_en ? rand_bit : ready_manual;

    always @(posedge clk) begin
        #1 rand_bit = ($urandom_range(0, 3) != 0);
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] ref_lane(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b_reg, input logic [15:0] imm,
                                               input logic immv);
        logic [DW-1:0] b;
        int unsigned x, y;
        int sh;
        b  = immv ? {{16{imm[15]}}, imm} : b_reg;
        sh = int'(imm[11:7]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b_reg;
            4'd2: begin x = a[15:0]; y = b[15:0]; return x * y; end
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return int'(a) >>> sh;
            4'd7: return a << sh;
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [NT-1:0] mask, input logic [WW-1:0] warp, input logic [31:0] instr,
                        input logic [NT*DW-1:0] s1, input logic [NT*DW-1:0] s2, input logic [4:0] dst,
                        input logic [15:0] imm, input logic immv, input logic rw, input logic [3:0] op,
                        input logic beq, input logic blt, input logic [SW-1:0] scb);
        logic acc;
        logic [NT*DW-1:0] data;
        logic [NT-1:0] taken;
        logic [DW-1:0] a, b;
        ActiveMask_OC_ALU = mask; WarpID_OC_ALU = warp; Instr_OC_ALU = instr;
        Src1_Data_OC_ALU = s1; Src2_Data_OC_ALU = s2; Dst_OC_ALU = dst;
        Imme_OC_ALU = imm; Imme_Valid_OC_ALU = immv; RegWrite_OC_ALU = rw;
        ALUop_OC_ALU = op; BEQ_OC_ALU = beq; BLT_OC_ALU = blt; ScbID_OC_ALU = scb;
        Valid_OC_ALU = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = Ready_ALU_OC;
            @(posedge clk);
            #1;
        end
        Valid_OC_ALU = 1'b0;
        chk("send_accepted", {319'd0, acc}, 320'd1);
        if (acc) begin
            if (rw) begin
                for (int i = 0; i < NT; i++) begin
                    a = s1[i*DW +: DW];
                    b = s2[i*DW +: DW];
                    data[i*DW +: DW] = mask[i] ? ref_lane(op, a, b, imm, immv) : '0;
                end
                exp_cdb_q.push_back({data, mask, instr, warp, dst});
            end else if (beq || blt) begin
                for (int i = 0; i < NT; i++) begin
                    a = s1[i*DW +: DW];
                    b = s2[i*DW +: DW];
                    taken[i] = mask[i] && (beq ? (a == b) : (int'(a) < int'(b)));
                end
                exp_br_q.push_back({taken, warp, {16'b0, imm}, warp, scb});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [NT*DW-1:0] rand_lanes();
        logic [NT*DW-1:0] v;
        for (int i = 0; i < NT; i++) begin
            case ($urandom_range(0, 7))
                0: v[i*DW +: DW] = 32'h0;
                1: v[i*DW +: DW] = 32'hFFFF_FFFF;
                2: v[i*DW +: DW] = 32'h8000_0000;
                3: v[i*DW +: DW] = 32'h7FFF_FFFF;
                default: v[i*DW +: DW] = $urandom;
            endcase
        end
        return v;
    endfunction

    function automatic logic [NT*DW-1:0] fill_lanes(input logic [DW-1:0] x);
        logic [NT*DW-1:0] v;
        for (int i = 0; i < NT; i++) v[i*DW +: DW] = x;
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic             stall_prev = 1'b0;
    logic [CDB_W-1:0] stall_snap;
    logic             saw_oc_low = 1'b0;

    always @(negedge clk) begin
        logic [CDB_W-1:0] got;
        logic [BR_W-1:0]  gbr;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (!Ready_ALU_OC) saw_oc_low = 1'b1;
            got = {Dst_Data_ALU_CDB, ActiveMask_ALU_CDB, Instr_ALU_CDB, WarpID_ALU_CDB, Dst_ALU_CDB};
            if (Valid_ALU_CDB) begin
                chk("cdb_regwrite", {319'd0, RegWrite_ALU_CDB}, 320'd1);
                if (stall_prev) chk("cdb_stable_in_stall", {16'd0, got}, {16'd0, stall_snap});
                if (Ready_CDB_ALU) begin
                    if (exp_cdb_q.size() == 0) begin
                        chk("cdb_unexpected", {16'd0, got}, 320'd0);
                    end else begin
                        chk("cdb_payload", {16'd0, got}, {16'd0, exp_cdb_q.pop_front()});
                    end
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    stall_snap = got;
                end
            end else begin
                if (stall_prev) chk("cdb_valid_dropped_in_stall", 320'd0, 320'd1);
                stall_prev = 1'b0;
                chk("cdb_idle_zero", {15'd0, RegWrite_ALU_CDB, got}, 320'd0);
            end
            gbr = {BrOutcome_ALU_SIMT, WarpID_ALU_SIMT, TargetAddr_ALU_PC, Clear_WarpID_ALU_Scb, Clear_ScbID_ALU_Scb};
            if (Br_ALU_SIMT) begin
                chk("br_clear_valid", {319'd0, Clear_Valid_ALU_Scb}, 320'd1);
                if (exp_br_q.size() == 0) begin
                    chk("br_unexpected", {275'd0, gbr}, 320'd0);
                end else begin
                    chk("br_payload", {275'd0, gbr}, {275'd0, exp_br_q.pop_front()});
                end
            end else begin
                chk("br_idle_zero", {274'd0, Clear_Valid_ALU_Scb, gbr}, 320'd0);
            end
        end
    end

    task automatic drain(input int limit);
        for (int c = 0; c < limit && (exp_cdb_q.size() != 0 || exp_br_q.size() != 0); c++) idle(1);
        chk("drain_cdb_q_empty", exp_cdb_q.size(), 320'd0);
        chk("drain_br_q_empty", exp_br_q.size(), 320'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [NT*DW-1:0] lanes_i;
    logic             b2b_seen;

    initial begin
        rst_n = 1'b0; Valid_OC_ALU = 1'b0; ready_manual = 1'b1; rand_en = 1'b0;
        ActiveMask_OC_ALU = '0; WarpID_OC_ALU = '0; Instr_OC_ALU = '0;
        Src1_Data_OC_ALU = '0; Src2_Data_OC_ALU = '0; Dst_OC_ALU = '0;
        Imme_OC_ALU = '0; Imme_Valid_OC_ALU = 1'b0; RegWrite_OC_ALU = 1'b0;
        ALUop_OC_ALU = '0; BEQ_OC_ALU = 1'b0; BLT_OC_ALU = 1'b0; ScbID_OC_ALU = '0;
        for (int i = 0; i < NT; i++) lanes_i[i*DW +: DW] = i;
        idle(3);
        rst_n = 1'b1;
        chk("reset_ready_oc", {319'd0, Ready_ALU_OC}, 320'd1);
        chk("reset_valid_cdb", {319'd0, Valid_ALU_CDB}, 320'd0);
        chk("reset_br", {319'd0, Br_ALU_SIMT}, 320'd0);

        // add with immediate -1: exact two-cycle latency
        send(8'hFF, 3'd1, 32'h0000_1111, lanes_i, '0, 5'd4, 16'hFFFF, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, '0);
        chk("latency_not_yet", {319'd0, Valid_ALU_CDB}, 320'd0);
        idle(1);
        chk("latency_valid", {319'd0, Valid_ALU_CDB}, 320'd1);
        chk("add_lane0", Dst_Data_ALU_CDB[0 +: DW], 320'hFFFF_FFFF);
        chk("add_lane5", Dst_Data_ALU_CDB[5*DW +: DW], 320'd4);
        idle(2);

        // masked xor
        send(8'b0000_0101, 3'd2, 32'h2222, rand_lanes(), fill_lanes(32'hFFFF_FFFF), 5'd7, 16'h0,
             1'b0, 1'b1, 4'd5, 1'b0, 1'b0, '0);
        idle(3);

        // BLT branch
        send(8'h0F, 3'd3, 32'h3333, fill_lanes(32'hFFFF_FFFF), '0, 5'd0, 16'h0040,
             1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd2);
        idle(3);

        // four back-to-back adds, CDB stalls 3 cycles from the second output
        saw_oc_low = 1'b0;
        b2b_seen   = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send(8'hFF, WW'(k), 32'h4000 + k, rand_lanes(), rand_lanes(), 5'(k + 1),
                         16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, '0);
            end
            begin
                for (int c = 0; c < 50 && !b2b_seen; c++) begin
                    @(negedge clk);
                    b2b_seen = Valid_ALU_CDB && Ready_CDB_ALU;
                end
                chk("b2b_first_output", {319'd0, b2b_seen}, 320'd1);
                @(posedge clk);
                #1 ready_manual = 1'b0;
                idle(3);
                ready_manual = 1'b1;
            end
        join
        drain(50);
        chk("b2b_oc_backpressure", {319'd0, saw_oc_low}, 320'd1);

        // branch retires under CDB backpressure; following ALU op waits
        ready_manual = 1'b0;
        send(8'hFF, 3'd5, 32'h5555, fill_lanes(32'd9), fill_lanes(32'd9), 5'd0, 16'h1234,
             1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd1);
        send(8'hFF, 3'd6, 32'h6666, rand_lanes(), rand_lanes(), 5'd9, 16'h0, 1'b0, 1'b1, 4'd3,
             1'b0, 1'b0, '0);
        idle(4);
        chk("br_retired_in_stall", exp_br_q.size(), 320'd0);
        chk("alu_waits_on_cdb", {319'd0, Valid_ALU_CDB}, 320'd1);
        ready_manual = 1'b1;
        drain(20);

        // reset with both stages full and stalled
        ready_manual = 1'b0;
        send(8'hFF, 3'd0, 32'h7777, rand_lanes(), rand_lanes(), 5'd1, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, '0);
        send(8'hFF, 3'd0, 32'h8888, rand_lanes(), rand_lanes(), 5'd2, 16'h0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, '0);
        chk("full_stall_ready_oc", {319'd0, Ready_ALU_OC}, 320'd0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        exp_cdb_q.delete();
        exp_br_q.delete();
        chk("post_reset_ready_oc", {319'd0, Ready_ALU_OC}, 320'd1);
        chk("post_reset_valid_cdb", {319'd0, Valid_ALU_CDB}, 320'd0);
        ready_manual = 1'b1;
        send(8'hFF, 3'd4, 32'h9999, fill_lanes(32'd1), '0, 5'd3, 16'h0F80, 1'b0, 1'b1, 4'd7,
             1'b0, 1'b0, '0);
        idle(1);
        chk("shl31_lane0", Dst_Data_ALU_CDB[0 +: DW], 320'h8000_0000);
        drain(20);

        // randomized traffic with random CDB backpressure
        rand_en = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int kind;
            logic bq, bl;
            logic [NT-1:0] m;
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 5))
                0: m = '0;
                1: m = '1;
                default: m = NT'($urandom);
            endcase
            bq = $urandom_range(0, 1);
            bl = ~bq | $urandom_range(0, 1);
            if (kind < 7)
                send(m, WW'($urandom), $urandom, rand_lanes(), rand_lanes(), 5'($urandom),
                     16'($urandom), 1'($urandom), 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, '0);
            else if (kind < 9)
                send(m, WW'($urandom), $urandom, rand_lanes(), rand_lanes(), 5'($urandom),
                     16'($urandom), 1'b0, 1'b0, 4'd0, bq, bl, SW'($urandom));
            else
                send(m, WW'($urandom), $urandom, rand_lanes(), rand_lanes(), 5'($urandom),
                     16'($urandom), 1'b0, 1'b0, 4'($urandom), 1'b0, 1'b0, '0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rand_en = 1'b0;
        ready_manual = 1'b1;
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
